// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan controller sharing one BCD decoder across DIGITS.
// Define SEG7_LZB_EN to blank leading zeros (digit 0 is always shown).
`timescale 1ns/1ps
module seg7_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int ON_CYC  = 4096,
  parameter int GAP_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_req,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ack,
  output logic [3:0]            dec_in,
  input  logic [6:0]            dec_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam int FW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FW-1:0]     active, pending, src;
  logic              pend_v;
  logic              bound, commit, capture;
  logic              lz, lit;
  logic [3:0]        dec_n;
  logic [DIGITS-1:0] an_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    bound   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ON;
          idx_n   = '0;
          cnt_n   = '0;
          bound   = 1'b1;
        end
        ON: begin
          if (cnt == CW'(ON_CYC - 1)) begin
            state_n = GAP;
            cnt_n   = '0;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYC - 1)) begin
            state_n = ON;
            cnt_n   = '0;
            if (idx == IW'(DIGITS - 1)) begin
              idx_n = '0;
              bound = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A commit on the boundary feeds the new frame straight into digit 0.
  always_comb begin
    commit  = bound & pend_v;
    capture = load_req & ~pend_v;
    src     = commit ? pending : active;
    dec_n   = dec_in;
    if (state_n == ON)
      dec_n = src[{idx_n, 2'b00} +: 4];
  end

  always_comb begin
`ifdef SEG7_LZB_EN
    lz = (idx != '0);
    for (int i = 0; i < DIGITS; i++)
      if (IW'(i) >= idx && active[4*i +: 4] != 4'd0)
        lz = 1'b0;
`else
    lz = 1'b0;
`endif
    lit  = (state == ON) && !lz;
    an_n = lit ? ~(DIGITS'(1) << idx) : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      active   <= '0;
      pending  <= '0;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
      frame    <= 1'b0;
      dec_in   <= '0;
      seg      <= '0;
      an       <= '1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      if (commit)
        active <= pending;
      if (capture)
        pending <= load_data;
      pend_v   <= capture | (pend_v & ~commit);
      load_ack <= capture;
      frame    <= bound;
      dec_in   <= dec_n;
      an       <= an_n;
      if (state == ON)
        seg <= dec_out;
    end
  end

endmodule
